// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction-fetch stage with a single-outstanding imem request/response port
// Presents a NOP bubble to IF/ID whenever no fetched instruction is held.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        kill_q, kill_d;

  logic [31:0] target;
  logic        unused_target_bits;

  assign target             = {PCTargetE[31:2], 2'b00};
  assign unused_target_bits = ^PCTargetE[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    kill_d  = kill_q;
    case (state_q)
      S_REQ: begin
        if (PCSrcE) pc_d = target;
        // A redirect on the acceptance edge leaves a stale response in flight.
        if (imem_ready) begin
          state_d = S_WAIT;
          kill_d  = PCSrcE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || PCSrcE) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (PCSrcE) pc_d = target;
          end else begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (PCSrcE) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_d    = target;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end else if (!StallF) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign Instruction = (state_q == S_HOLD) ? instr_q : NOP_INSTR;
  assign FetchBusy   = (state_q != S_HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Memory model plus a transaction-level scoreboard of presented (pc, instruction) pairs.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] DEAD   = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, Instruction, PCPlus4;
  logic        FetchBusy;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
    .Instruction(Instruction), .PCPlus4(PCPlus4), .FetchBusy(FetchBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory model and scoreboard state
  bit          rand_ready = 0;
  int          lat_lo = 0, lat_hi = 0;
  bit          outstanding = 0;
  logic [31:0] out_addr = '0;
  int          cnt = 0;
  bit          poison_en = 0;
  logic [31:0] poison_addr = '0;
  logic [31:0] exp_next = RST_PC;
  logic [31:0] last_acc_addr = '0;
  int          acc_n = 0;
  int          pres_cnt = 0;
  int          cyc = 0;
  logic [31:0] last_pres_pc = '0, last_pres_instr = '0;
  int          last_pres_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (poison_en && a == poison_addr) return DEAD;
    if (a[31:18] == 14'd0) return {16'hAAAA, a[17:2]} + 32'd1;
    return a ^ 32'h1234_5678;
  endfunction

  // One clock: drive inputs, model the edge, then check outputs 1 time unit after it.
  task automatic tick(input logic st, input logic src, input logic [31:0] tgt);
    logic        accept, respond, pres, hold, was_busy;
    logic [31:0] acc_addr, old_pc, old_instr;
    StallF = st; PCSrcE = src; PCTargetE = tgt;
    imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (outstanding && cnt == 0) begin
      imem_rvalid = 1'b1; imem_rdata = mem_data(out_addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    accept    = imem_req && imem_ready;
    respond   = imem_rvalid;
    acc_addr  = imem_addr;
    pres      = !FetchBusy;
    was_busy  = FetchBusy;
    old_pc    = pc;
    old_instr = Instruction;
    if (src) exp_next = {tgt[31:2], 2'b00};
    else if (pres && !st) exp_next = pc + 32'd4;
    hold = pres && st && !src;
    @(posedge clk); #1;
    cyc++;
    if (respond) outstanding = 0;
    else if (outstanding) cnt--;
    if (accept) begin
      check("one_outstanding", 32'(outstanding), 32'd0);
      outstanding = 1; out_addr = acc_addr; cnt = $urandom_range(lat_lo, lat_hi);
      last_acc_addr = acc_addr; acc_n++;
    end
    check("pcplus4", PCPlus4, pc + 32'd4);
    check("addr_is_pc", imem_addr, pc);
    if (FetchBusy) check("bubble", Instruction, NOP);
    else begin
      check("instr_data", Instruction, mem_data(pc));
      check("no_req_hold", 32'(imem_req), 32'd0);
    end
    if (imem_req) check("req_idle", 32'(outstanding), 32'd0);
    if (!FetchBusy && was_busy) begin
      check("pres_pc", pc, exp_next);
      pres_cnt++; last_pres_pc = pc; last_pres_instr = Instruction; last_pres_cyc = cyc;
    end
    if (hold) begin
      check("hold_busy", 32'(FetchBusy), 32'd0);
      check("hold_pc", pc, old_pc);
      check("hold_instr", Instruction, old_instr);
    end
    if (poison_en) check("no_killed_data", 32'(Instruction == DEAD), 32'd0);
  endtask

  task automatic wait_pres(input string tag);
    int n0;
    n0 = pres_cnt;
    for (int i = 0; i < 40 && pres_cnt == n0; i++) tick(1'b0, 1'b0, 32'd0);
    check({tag, "_seen"}, 32'(pres_cnt != n0), 32'd1);
  endtask

  initial begin
    int c0, a0, p0;
    logic st, src;
    logic [31:0] tgt;
    rst = 1'b1; StallF = 0; PCSrcE = 0; PCTargetE = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_pcplus4", PCPlus4, 32'h104);
    check("rst_instr", Instruction, NOP);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_busy", 32'(FetchBusy), 32'd1);
    @(negedge clk); rst = 1'b0; #1;
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr", imem_addr, RST_PC);

    // zero-wait memory, redirect to 0 on the first accepted request
    tick(1'b0, 1'b1, 32'h0);
    wait_pres("zw0");
    check("zw0_pc", last_pres_pc, 32'h0);
    check("zw0_instr", last_pres_instr, 32'hAAAA_0001);
    c0 = last_pres_cyc;
    wait_pres("zw1");
    check("zw1_pc", last_pres_pc, 32'h4);
    check("zw1_instr", last_pres_instr, 32'hAAAA_0002);
    check("zw_spacing", 32'(last_pres_cyc - c0), 32'd3);

    // stall in HOLD for four cycles, then release
    repeat (4) begin
      tick(1'b1, 1'b0, 32'h0);
      check("stall_pc", pc, 32'h4);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    tick(1'b0, 1'b0, 32'h0);
    check("stall_rel_addr", imem_addr, 32'h8);
    check("stall_rel_req", 32'(imem_req), 32'd1);

    // redirect during WAIT; killed response arrives two cycles later
    lat_lo = 2; lat_hi = 2; poison_en = 1; poison_addr = 32'h8;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h203);
    a0 = acc_n;
    wait_pres("kill");
    check("kill_pc", last_pres_pc, 32'h200);
    check("kill_acc_cnt", 32'(acc_n - a0), 32'd1);
    check("kill_acc_addr", last_acc_addr, 32'h200);
    poison_en = 0; lat_lo = 0; lat_hi = 0;

    // redirect beats stall in HOLD
    tick(1'b0, 1'b1, 32'h40);
    wait_pres("hold40");
    check("hold40_pc", pc, 32'h40);
    tick(1'b1, 1'b1, 32'h80);
    check("prio_busy", 32'(FetchBusy), 32'd1);
    check("prio_req", 32'(imem_req), 32'd1);
    check("prio_addr", imem_addr, 32'h80);
    check("prio_instr", Instruction, NOP);

    // PC wrap at the top of the address space
    tick(1'b0, 1'b1, 32'hFFFF_FFFF);
    wait_pres("wrap");
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", 32'(imem_req), 32'd1);

    // randomized traffic against the scoreboard
    rand_ready = 1; lat_lo = 0; lat_hi = 3;
    p0 = pres_cnt;
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 9) < 3);
      src = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick(st, src, tgt);
    end
    check("rand_progress", 32'((pres_cnt - p0) > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
